sevenseg_scan: RTL and testbench
================================

# sevenseg_scan

Parametrised time-multiplexed driver for a common-anode seven-segment display bank (PNP anode drivers, active-low anodes and segments). It sits between the stopwatch/counter datapath and the board pins. It adds the following:
- parametrised digit count and dwell time
- hex decode
- decimal points and per-digit enables
- leading-zero blanking
- frame-synchronous double-buffered loads (no tearing)
- an anti-ghosting blank interval between digits

## Interface
- N_DIGITS, 8, number of digits scanned; legal 1..16.
- DWELL_CYCLES, 100000, clock cycles each digit slot lasts (1 ms at 100 MHz); legal ≥ 2.
- BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off; legal 0..DWELL_CYCLES-1.
- i_clk  in  1  system clock.
- i_rst  in  1  reset i_rst, asynchronous, active-high; clock i_clk.
- i_load  in  1  strobe, captures i_digits/i_dp/i_en into staging.
- i_digits  in  4*N_DIGITS  hex nibble per digit; digit k = bits [4k+3:4k], digit 0 rightmost.
- i_dp  in  N_DIGITS  decimal point request per digit, 1 = lit.
- i_en  in  N_DIGITS  digit enable, 1 = shown.
- i_lz_blank  in  1  leading-zero blanking mode, sampled live (not buffered).
- o_an  out  N_DIGITS  anodes, active-low.
- o_seg  out  7  segments, active-low, bit0=a … bit6=g.
- o_dp  out  1  decimal point, active-low.
- o_frame  out  1  one-cycle pulse at start of each frame.

## Operation
- Prescaler cnt counts 0..DWELL_CYCLES-1 and wraps. Digit index idx advances when cnt = DWELL_CYCLES-1, and wraps N_DIGITS-1 → 0 (frame boundary).
- **Buffering:**
  - i_load copies inputs into staging and sets pending.
  - At the frame boundary, if pending, staging is copied to active and pending clears.
  - If i_load coincides with the boundary, the inputs presented that cycle go straight to active and pending clears.
  - Repeated i_load within a frame: the last one wins.
- **Decode:** standard hex 0-F. Required active-low codes: 0=0x40, 1=0x79, 8=0x00, A=0x08, F=0x0E. Blank = 0x7F.
- **Leading-zero blanking:** when i_lz_blank = 1, digit k ≥ 1 is blanked if digit k and every enabled digit above it are 0. Digit 0 is never blanked. Disabled digits count as zero.
- **Blanked or disabled digit:**
  - Anode stays high for its slot; the slot time is still consumed.
  - o_seg = 0x7F; o_dp = 1.
  - A blanked digit's decimal point is still shown if requested; a disabled digit's is not.
- All outputs are registered.

## Timing
- **Reset values:** o_an = all 1, o_seg = 0x7F, o_dp = 1, o_frame = 0. cnt = 0, idx = 0, pending = 0. Active/staging digits = 0, dp = 0, en = 0, so the display is dark until the first applied load.
- **Within a slot:** o_an is all 1 for slot cycles 0..BLANK_CYCLES-1. The selected anode is low for the remaining DWELL_CYCLES-BLANK_CYCLES cycles.
- o_seg/o_dp change only on slot cycle 0, while anodes are off (when BLANK_CYCLES ≥ 1).
- Output latency: 1 cycle from the internal cnt/idx state to the pins.
- Frame period is exactly N_DIGITS*DWELL_CYCLES cycles.
- o_frame is high for the single cycle in which digit 0's slot cycle 0 appears on the outputs. It is the first such cycle one cycle after reset release, i.e. in the same cycle as the first slot's outputs.
- A load becomes visible on the pins at the first o_frame after the boundary that applies it.
- Reset mid-frame returns all outputs to reset values asynchronously and discards both staging and active contents.

## Structure
- Package sevenseg_pkg holds:
  - SEG_BLANK = 7'h7F
  - the 16-entry hex → segment constant table / function
  - the anode-off constant helper
- Sub-module sevenseg_decode: combinational nibble + blank → 7-bit active-low segments. Instantiated once, on the muxed digit.
- Top is counters, staging/active registers, the leading-zero mask chain, and output registers.

## Test plan
Bench configuration: N_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=1.

1. Reset, no load → o_an=4'hF, o_seg=0x7F, o_dp=1 for 100 cycles; o_frame pulses every 16 cycles.
2. Load digits 0x1234, en=4'hF, dp=4'b0100 → after the next boundary:
   - per slot: one cycle o_an=4'hF, then three cycles of 4'b1110/4'b1101/4'b1011/4'b0111
   - o_seg sequence shows 4, 3, 2, 1
   - o_dp=0 only in digit 2's slot
3. Load 0x0008 with i_lz_blank=1 → digits 3..1 anodes stay high and digit 0 shows 0x00. Load 0x0000 → digit 0 shows 0x40.
4. i_load pulsed mid-frame with 0xFFFF → pins keep the old value until o_frame, then show 0x0E on every digit. i_load coincident with the boundary → applied at that same frame.
5. Assert i_rst mid-slot with a digit lit → o_an=4'hF and o_seg=0x7F immediately. After release the display stays dark until a new load.
6. en=4'b0101 → anodes 1 and 3 never go low; slot timing and the 16-cycle frame period are unchanged.

Source files
------------

// File: rtl/sevenseg_scan_pkg.sv
// sevenseg_pkg: shared constants and helpers for the seven-segment scan driver.
//   SEG_W       - segment bus width (a..g)
//   SEG_BLANK   - active-low "all segments off" code
//   MAX_DIGITS  - largest digit bank the driver supports
//   hex_to_seg  - hex nibble -> active-low segment code, bit0=a .. bit6=g
//   an_all_off  - all anodes off (active-low), MAX_DIGITS wide
package sevenseg_pkg;

  localparam int SEG_W      = 7;
  localparam int MAX_DIGITS = 16;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // PNP anode drivers: a 1 turns the digit off.
  function automatic logic [MAX_DIGITS-1:0] an_all_off();
    return {MAX_DIGITS{1'b1}};
  endfunction

endpackage

// File: rtl/sevenseg_scan_if.sv
// sevenseg_scan_if: datapath-side load bus and display-pin outputs of the
// scan driver.
//   i_load      - strobe, captures i_digits/i_dp/i_en into staging
//   i_digits    - hex nibble per digit, digit k = [4k+3:4k], digit 0 rightmost
//   i_dp        - decimal point request per digit (1 = lit)
//   i_en        - digit enable (1 = shown)
//   i_lz_blank  - leading-zero blanking mode, used live
//   o_an        - anodes, active-low
//   o_seg       - segments, active-low, bit0=a .. bit6=g
//   o_dp        - decimal point, active-low
//   o_frame     - one-cycle pulse when digit 0's slot starts on the pins
// Load semantics: i_load is a single-cycle strobe with no back-pressure; every
// cycle it is high is a load, and the last one before a frame boundary wins.
interface sevenseg_scan_if
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS = 8
);

  logic                  i_load;
  logic [4*N_DIGITS-1:0] i_digits;
  logic [N_DIGITS-1:0]   i_dp;
  logic [N_DIGITS-1:0]   i_en;
  logic                  i_lz_blank;
  logic [N_DIGITS-1:0]   o_an;
  logic [SEG_W-1:0]      o_seg;
  logic                  o_dp;
  logic                  o_frame;

  modport master (
    output i_load, i_digits, i_dp, i_en, i_lz_blank,
    input  o_an, o_seg, o_dp, o_frame
  );

  modport slave (
    input  i_load, i_digits, i_dp, i_en, i_lz_blank,
    output o_an, o_seg, o_dp, o_frame
  );

endinterface

// File: rtl/sevenseg_scan_decode.sv
// sevenseg_decode: combinational hex nibble -> active-low segment code.
//   nibble - hex value of the digit
//   blank  - force all segments off
//   seg    - active-low segments, bit0=a .. bit6=g
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : hex_to_seg(nibble);
  end

endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed driver for a common-anode seven-segment bank.
//   i_clk  - system clock
//   i_rst  - asynchronous active-high reset
//   bus    - sevenseg_scan_if slave: load bus in, display pins out
// Each digit owns a slot of DWELL_CYCLES clocks; the first BLANK_CYCLES of a
// slot keep every anode off so the segment change never ghosts onto the
// neighbouring digit. New data is double-buffered and swapped in only at the
// frame boundary, so a frame is never drawn from two different loads.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  sevenseg_scan_if.slave bus
);

  localparam int CW = $clog2(DWELL_CYCLES);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [MAX_DIGITS-1:0] AN_OFF_FULL = an_all_off();
  localparam logic [N_DIGITS-1:0]   AN_OFF      = AN_OFF_FULL[N_DIGITS-1:0];

  // Scan position
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          slot_end;
  logic          frame_end;

  // Staging and active copies of the display contents
  logic [4*N_DIGITS-1:0] stg_digits, act_digits;
  logic [N_DIGITS-1:0]   stg_dp, act_dp;
  logic [N_DIGITS-1:0]   stg_en, act_en;
  logic                  pending;

  // Current-digit view
  logic [N_DIGITS-1:0] lz_mask;
  logic [3:0]          cur_nib;
  logic                cur_en;
  logic                cur_blank;
  logic [SEG_W-1:0]    cur_seg;
  logic                dp_lit_c;
  logic                shown_now;
  logic                in_blank;
  logic [N_DIGITS-1:0] an_sel;

  // Output and slot-hold registers
  logic [N_DIGITS-1:0] an_q;
  logic [SEG_W-1:0]    seg_q;
  logic                dp_q;
  logic                frame_q;
  logic                shown_q;

  assign slot_end  = (cnt == CW'(DWELL_CYCLES - 1));
  assign frame_end = slot_end && (idx == IW'(N_DIGITS - 1));

  // Leading-zero chain from the top digit down: a digit is blanked while it
  // and everything above it reads as zero. Disabled digits read as zero.
  always_comb begin
    logic run;
    lz_mask = '0;
    run     = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      run        = run & (~act_en[k] | (act_digits[4*k +: 4] == 4'h0));
      lz_mask[k] = run & bus.i_lz_blank;
    end
  end

  assign cur_nib   = act_digits[4*int'(idx) +: 4];
  assign cur_en    = act_en[idx];
  assign cur_blank = lz_mask[idx] | ~cur_en;
  // A blanked digit keeps its decimal point; a disabled one does not.
  assign dp_lit_c  = act_dp[idx] & cur_en;

  sevenseg_decode u_decode (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .seg    (cur_seg)
  );

  // Visibility is decided once at slot cycle 0 and held for the slot, so a
  // change of i_lz_blank mid-slot cannot flash the anode.
  assign shown_now = (cnt == '0) ? ~cur_blank : shown_q;
  assign in_blank  = (BLANK_CYCLES != 0) && (int'(cnt) < BLANK_CYCLES);
  assign an_sel    = ~(N_DIGITS'(1) << idx);

  // Scan counters and double buffer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      stg_digits <= '0;
      stg_dp     <= '0;
      stg_en     <= '0;
      act_digits <= '0;
      act_dp     <= '0;
      act_en     <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        idx <= frame_end ? '0 : idx + IW'(1);
      end

      if (frame_end) begin
        // A load on the boundary cycle bypasses staging.
        if (bus.i_load) begin
          act_digits <= bus.i_digits;
          act_dp     <= bus.i_dp;
          act_en     <= bus.i_en;
        end else if (pending) begin
          act_digits <= stg_digits;
          act_dp     <= stg_dp;
          act_en     <= stg_en;
        end
        pending <= 1'b0;
      end else if (bus.i_load) begin
        stg_digits <= bus.i_digits;
        stg_dp     <= bus.i_dp;
        stg_en     <= bus.i_en;
        pending    <= 1'b1;
      end
    end
  end

  // Output registers: one cycle behind cnt/idx
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
      shown_q <= 1'b0;
    end else begin
      frame_q <= (cnt == '0) && (idx == '0);
      shown_q <= shown_now;
      if (cnt == '0) begin
        seg_q <= cur_seg;
        dp_q  <= ~dp_lit_c;
      end
      an_q <= (in_blank || !shown_now) ? AN_OFF : an_sel;
    end
  end

  assign bus.o_an    = an_q;
  assign bus.o_seg   = seg_q;
  assign bus.o_dp    = dp_q;
  assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: directed bench for sevenseg_scan with 4 digits, 4-cycle
// slots and a 1-cycle anti-ghost blank. Outputs are sampled on the falling
// edge; expected frames are hand-computed segment codes per slot.
module tb_sevenseg_scan;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int BL = 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sevenseg_scan_if #(.N_DIGITS(N)) bus ();

  sevenseg_scan #(
    .N_DIGITS     (N),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One sampled cycle of a frame. c = cycle within frame (0..15).
  // lit: digits whose anode goes low; segv: {slot3..slot0} codes; dpv: o_dp low.
  task automatic check_cycle(input int c, input logic [3:0] lit,
                             input logic [27:0] segv, input logic [3:0] dpv,
                             input string tag);
    int         s;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    s       = c / DW;
    exp_an  = ((c % DW) < BL || !lit[s]) ? 4'hF : ~(4'b0001 << s);
    exp_seg = segv[7*s +: 7];
    chk($sformatf("%s_c%0d_an", tag, c), {4'h0, bus.o_an}, {4'h0, exp_an});
    chk($sformatf("%s_c%0d_seg", tag, c), {1'b0, bus.o_seg}, {1'b0, exp_seg});
    chk($sformatf("%s_c%0d_dp", tag, c), {7'h0, bus.o_dp}, {7'h0, ~dpv[s]});
    chk($sformatf("%s_c%0d_frame", tag, c), {7'h0, bus.o_frame}, {7'h0, (c == 0)});
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_frame !== 1'b1 && n < 40);
    chk("wait_frame", {7'h0, bus.o_frame}, 8'h01);
  endtask

  task automatic check_frame(input logic [3:0] lit, input logic [27:0] segv,
                             input logic [3:0] dpv, input string tag);
    wait_frame();
    for (int c = 0; c < N*DW; c++) begin
      if (c != 0) @(negedge clk);
      check_cycle(c, lit, segv, dpv, tag);
    end
  endtask

  // Check cycles from..15 of the frame in progress, one falling edge each.
  task automatic check_rest(input int from, input logic [3:0] lit,
                            input logic [27:0] segv, input logic [3:0] dpv,
                            input string tag);
    for (int c = from; c < N*DW; c++) begin
      @(negedge clk);
      check_cycle(c, lit, segv, dpv, tag);
    end
  endtask

  task automatic pulse_load(input logic [15:0] digits, input logic [3:0] en,
                            input logic [3:0] dp);
    bus.i_digits = digits;
    bus.i_en     = en;
    bus.i_dp     = dp;
    bus.i_load   = 1'b1;
    @(posedge clk);
    #1 bus.i_load = 1'b0;
  endtask

  task automatic mid_frame();
    wait_frame();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.i_load     = 1'b0;
    bus.i_digits   = '0;
    bus.i_dp       = '0;
    bus.i_en       = '0;
    bus.i_lz_blank = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_an", {4'h0, bus.o_an}, 8'h0F);
    chk("rst_seg", {1'b0, bus.o_seg}, 8'h7F);
    chk("rst_dp", {7'h0, bus.o_dp}, 8'h01);
    chk("rst_frame", {7'h0, bus.o_frame}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: dark for 100 cycles, frame pulse every 16
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_cycle(i % 16, 4'b0000, 28'hFFFFFFF, 4'b0000, "dark");
    end

    // 2: two loads within one frame, last wins: 0x1234, dp on digit 2
    pulse_load(16'hAAAA, 4'hF, 4'b0000);
    @(negedge clk);
    pulse_load(16'h1234, 4'hF, 4'b0100);
    check_frame(4'hF, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0100, "d1234");

    // 3: leading-zero blanking
    bus.i_lz_blank = 1'b1;
    mid_frame();
    pulse_load(16'h0008, 4'hF, 4'b0100);
    check_frame(4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h00}, 4'b0100, "lz0008");
    mid_frame();
    pulse_load(16'h0000, 4'hF, 4'b0000);
    check_frame(4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000, "lz0000");
    mid_frame();
    pulse_load(16'h0105, 4'hF, 4'b0000);
    check_frame(4'b0111, {7'h7F, 7'h79, 7'h40, 7'h12}, 4'b0000, "lz0105");

    // 4: mid-frame load holds until the next frame
    mid_frame();
    pulse_load(16'hFFFF, 4'hF, 4'b0000);
    check_rest(4, 4'b0111, {7'h7F, 7'h79, 7'h40, 7'h12}, 4'b0000, "hold");
    check_frame(4'hF, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'b0000, "dFFFF");

    // 4b: load on the boundary cycle applies to the very next frame
    wait_frame();
    repeat (14) @(negedge clk);
    pulse_load(16'h5678, 4'hF, 4'b0001);
    check_frame(4'hF, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0001, "bnd5678");

    // 5: asynchronous reset mid-slot with digit 0 lit
    wait_frame();
    repeat (2) @(negedge clk);
    chk("pre_rst_an", {4'h0, bus.o_an}, 8'h0E);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", {4'h0, bus.o_an}, 8'h0F);
    chk("arst_seg", {1'b0, bus.o_seg}, 8'h7F);
    chk("arst_dp", {7'h0, bus.o_dp}, 8'h01);
    chk("arst_frame", {7'h0, bus.o_frame}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.i_lz_blank = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check_cycle(i % 16, 4'b0000, 28'hFFFFFFF, 4'b0000, "dark2");
    end

    // 6: digits 1 and 3 disabled; digit 1's dp request must not show
    pulse_load(16'h1234, 4'b0101, 4'b0010);
    check_frame(4'b0101, {7'h7F, 7'h24, 7'h7F, 7'h19}, 4'b0000, "en0101");
    check_rest(0, 4'b0101, {7'h7F, 7'h24, 7'h7F, 7'h19}, 4'b0000, "en0101b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
